// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the stream UART transmitter
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
    localparam int   FRAME_BITS = 10;
    localparam logic UART_IDLE  = 1'b1;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period down-counter; tick marks the last cycle of each bit period
//   clk, rst : clock and synchronous active-high reset
//   load     : reload the counter with div (start of a frame or end of a bit)
//   div      : bit period minus one, in clk cycles
//   tick     : high in the final cycle of the current bit period
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    assign tick = cnt == '0;
    // Reload is to div, not div+1, so an all-ones divider never overflows.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= div;
        else if (cnt != '0) cnt <= cnt - DIV_W'(1);
    end
endmodule

// File: rtl/stream_uart_tx.sv
// stream_uart_tx: AXI4-stream byte sink serialised onto an 8N1 UART line with packet gap
//   clk, rst : clock and synchronous active-high reset
//   baud_div : bit period minus one, latched per accepted byte
//   s_data, s_valid, s_last, s_ready : stream input handshake
//   txd      : registered UART output, idle high
//   busy     : frame or post-packet gap in progress
//   pkt_done : one-cycle pulse after a last byte's frame and gap
module stream_uart_tx
    import uart_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DIV_W    = 16,
    parameter int GAP_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             txd,
    output logic             busy,
    output logic             pkt_done
);
    localparam int GW = GAP_BITS > 0 ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

    if (DW != 8) begin : g_bad_dw
        $error("stream_uart_tx supports only DW=8");
    end

    state_t           state;
    logic [DW-1:0]    sh;
    logic [2:0]       bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [DIV_W-1:0] div_q;
    logic             last_q;
    logic             tick;
    logic             xfer;

    assign s_ready = state == IDLE && !rst;
    assign xfer    = s_valid && s_ready;
    assign busy    = state != IDLE;

    // The timer restarts on acceptance with the fresh divider, then reloads
    // from the latched copy so mid-frame divider changes are ignored.
    uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (xfer || tick),
        .div  (xfer ? baud_div : div_q),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= UART_IDLE;
            pkt_done <= 1'b0;
            sh       <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            div_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: if (xfer) begin
                    state  <= START;
                    txd    <= 1'b0;
                    sh     <= s_data;
                    last_q <= s_last;
                    div_q  <= baud_div;
                end
                START: if (tick) begin
                    state   <= DATA;
                    txd     <= sh[0];
                    sh      <= sh >> 1;
                    bit_cnt <= '0;
                end
                DATA: if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state <= STOP;
                        txd   <= UART_IDLE;
                    end else begin
                        txd     <= sh[0];
                        sh      <= sh >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP: if (tick) begin
                    if (last_q && GAP_BITS > 0) begin
                        state   <= GAP;
                        gap_cnt <= GW'(GAP_BITS - 1);
                    end else begin
                        state    <= IDLE;
                        pkt_done <= last_q;
                    end
                end
                GAP: if (tick) begin
                    if (gap_cnt == '0) begin
                        state    <= IDLE;
                        pkt_done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_uart_tx.sv
// tb_stream_uart_tx: scoreboard bench; accepted bytes are queued and a line monitor checks every cycle
module tb_stream_uart_tx;
    import uart_pkg::*;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = '0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready, txd, busy, pkt_done;

    always #5 clk = ~clk;

    stream_uart_tx #(.DW(8), .DIV_W(16), .GAP_BITS(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .txd      (txd),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         p;
        int         t;
    } fr_t;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  tx_n = 0;
    int  pd_n = 0;
    fr_t q[$];
    fr_t cur;
    bit  have = 0;
    int  end_c = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
        end
    endtask

    // Scoreboard push: every accepted byte with the period it must use.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pkt_done) pd_n <= pd_n + 1;
        if (!rst && s_valid && s_ready) begin
            q.push_back('{s_data, s_last, int'(baud_div) + 1, cyc});
            tx_n <= tx_n + 1;
        end
    end

    // Monitor: expected line state from frame arithmetic (start, 8 data LSB first, stop, gap).
    always @(negedge clk) begin
        int   k;
        int   idx;
        logic et, eb, ep;
        if (rst) begin
            chk("ready_in_rst", 32'(s_ready), 32'd0);
            q.delete();
            have = 0;
        end else begin
            if (!have && q.size() > 0 && q[0].t < cyc) begin
                cur = q.pop_front();
                have = 1;
                end_c = cur.t + FRAME_BITS * cur.p + (cur.l ? G * cur.p : 0);
            end
            et = 1'b1;
            eb = 1'b0;
            ep = 1'b0;
            if (have && cyc > cur.t && cyc <= end_c) begin
                eb = 1'b1;
                k = cyc - cur.t - 1;
                idx = k / cur.p;
                if (idx == 0) et = 1'b0;
                else if (idx <= 8) et = cur.d[idx-1];
            end
            if (have && cur.l && cyc == end_c + 1) ep = 1'b1;
            chk("line{txd,busy,pd,ready}", 32'({txd, busy, pkt_done, s_ready}), 32'({et, eb, ep, !eb}));
            if (have && cyc > end_c) have = 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic [15:0] div, input bit hold);
        int n = 0;
        s_data = d;
        s_last = l;
        baud_div = div;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(s_ready), 32'd1);
        if (!s_ready) begin
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || have || q.size() != 0) && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pd", 32'(pkt_done), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        p0 = pd_n;
        send(8'hA5, 1'b0, 16'd3, 1'b0);
        wait_idle();
        idle(5);
        chk("single_no_pd", 32'(pd_n - p0), 32'd0);

        p0 = pd_n;
        send(8'h00, 1'b0, 16'd0, 1'b1);
        send(8'hFF, 1'b1, 16'd0, 1'b0);
        wait_idle();
        idle(2);
        chk("b2b_pd_once", 32'(pd_n - p0), 32'd1);

        send(8'h3C, 1'b0, 16'd7, 1'b0);
        idle(18);
        baud_div = 16'd1;
        wait_idle();
        send(8'($urandom), 1'b0, 16'd1, 1'b0);
        wait_idle();

        p0 = pd_n;
        send(8'($urandom), 1'b1, 16'd2, 1'b0);
        idle(16);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        send(8'h55, 1'b0, 16'd3, 1'b0);
        wait_idle();
        idle(3);
        chk("abort_no_pd", 32'(pd_n - p0), 32'd0);

        p0 = pd_n;
        n0 = tx_n;
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 16'd2, 1'b1);
        send(8'($urandom), 1'b1, 16'd2, 1'b0);
        wait_idle();
        idle(2);
        chk("bp_transfers", 32'(tx_n - n0), 32'd4);
        chk("bp_pd_once", 32'(pd_n - p0), 32'd1);

        send(8'h01, 1'b0, 16'd299, 1'b0);
        wait_idle();

        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) baud_div = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 15));
        end
        s_valid = 1'b0;
        wait_idle();
        idle(2);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
